// File: rtl/quad_enc_gen_if.sv
// Step/dir command and quadrature output bundle for quad_enc_gen.
// The enc_z index line exists only when QUAD_ENC_INDEX_EN is defined.
interface quad_enc_gen_if #(
    parameter int COUNTBITS = 16,
    parameter int DIVBITS   = 16,
    parameter int POSBITS   = 32
);
    logic                 step;
    logic                 dir;
    logic                 enable;
    logic [DIVBITS-1:0]   edge_period;
    logic                 clear_overflow;
    logic                 enc_a;
    logic                 enc_b;
    logic [POSBITS-1:0]   position;
    logic [COUNTBITS-1:0] pending;
    logic                 busy;
    logic                 overflow;
`ifdef QUAD_ENC_INDEX_EN
    logic                 enc_z;

    modport master (
        output step, dir, enable, edge_period, clear_overflow,
        input  enc_a, enc_b, enc_z, position, pending, busy, overflow
    );

    modport slave (
        input  step, dir, enable, edge_period, clear_overflow,
        output enc_a, enc_b, enc_z, position, pending, busy, overflow
    );
`else
    modport master (
        output step, dir, enable, edge_period, clear_overflow,
        input  enc_a, enc_b, position, pending, busy, overflow
    );

    modport slave (
        input  step, dir, enable, edge_period, clear_overflow,
        output enc_a, enc_b, position, pending, busy, overflow
    );
`endif
endinterface

// File: rtl/quad_enc_gen.sv
// Quadrature encoder generator: turns step/dir pulses into rate-limited A/B edges.
// Define QUAD_ENC_INDEX_EN to add the CPR parameter, index counter and enc_z output.
module quad_enc_gen #(
    parameter int COUNTBITS = 16,
    parameter int DIVBITS   = 16,
    parameter int POSBITS   = 32
`ifdef QUAD_ENC_INDEX_EN
    ,
    parameter int CPR       = 4000
`endif
) (
    input  logic          CLK,
    input  logic          reset,
    quad_enc_gen_if.slave bus
);

    // Pending arithmetic runs one bit wider so saturation can be detected.
    localparam logic [COUNTBITS:0] EXT_ONE       = {{COUNTBITS{1'b0}}, 1'b1};
    localparam logic [COUNTBITS:0] EXT_MINUS_ONE = {(COUNTBITS+1){1'b1}};
    localparam logic [COUNTBITS:0] PEND_MAX      = {2'b00, {(COUNTBITS-1){1'b1}}};
    localparam logic [COUNTBITS:0] PEND_MIN      = ~PEND_MAX + EXT_ONE;
    localparam logic [POSBITS-1:0] POS_ONE       = {{(POSBITS-1){1'b0}}, 1'b1};
    localparam logic [DIVBITS-1:0] DIV_ONE       = {{(DIVBITS-1){1'b0}}, 1'b1};

    logic                 step_q, step_d;
    logic                 enc_a_q, enc_a_d;
    logic                 enc_b_q, enc_b_d;
    logic [POSBITS-1:0]   position_q, position_d;
    logic [COUNTBITS-1:0] pending_q, pending_d;
    logic [DIVBITS-1:0]   divider_q, divider_d;
    logic                 busy_q, busy_d;
    logic                 overflow_q, overflow_d;

    logic                 step_ev;
    logic                 fire;
    logic                 fwd;
    logic                 toggle_a;
    logic                 overflow_set;
    logic [COUNTBITS:0]   pend_ext;
    logic [COUNTBITS:0]   delta_in;
    logic [COUNTBITS:0]   delta_out;
    logic [COUNTBITS:0]   pend_sum;
    logic [COUNTBITS:0]   pend_next;
    logic [DIVBITS-1:0]   divider_load;

    always_comb begin
        step_d       = bus.step;
        step_ev      = bus.step & ~step_q & bus.enable;
        fire         = (divider_q == '0) && (pending_q != '0) && bus.enable;
        fwd          = ~pending_q[COUNTBITS-1];

        pend_ext     = {pending_q[COUNTBITS-1], pending_q};
        delta_in     = '0;
        delta_out    = '0;
        if (step_ev) begin
            delta_in = bus.dir ? EXT_ONE : EXT_MINUS_ONE;
        end
        if (fire) begin
            delta_out = fwd ? EXT_ONE : EXT_MINUS_ONE;
        end
        pend_sum     = pend_ext + delta_in - delta_out;

        // A step that would push past the limit is dropped; the fire still counts.
        overflow_set = 1'b0;
        pend_next    = pend_sum;
        if (($signed(pend_sum) > $signed(PEND_MAX)) ||
            ($signed(pend_sum) < $signed(PEND_MIN))) begin
            overflow_set = 1'b1;
            pend_next    = pend_ext - delta_out;
        end

        divider_load = (bus.edge_period == '0) ? '0 : (bus.edge_period - DIV_ONE);

        if (!bus.enable) begin
            pending_d = '0;
            divider_d = '0;
        end else begin
            pending_d = pend_next[COUNTBITS-1:0];
            if (fire) begin
                divider_d = divider_load;
            end else if (divider_q != '0) begin
                divider_d = divider_q - DIV_ONE;
            end else begin
                divider_d = divider_q;
            end
        end

        busy_d = (pending_d != '0);

        if (overflow_set && bus.enable) begin
            overflow_d = 1'b1;
        end else if (bus.clear_overflow) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Forward walks 00->10->11->01: A toggles when A==B, B otherwise; reverse swaps.
    always_comb begin
        toggle_a   = ((enc_a_q == enc_b_q) == fwd);
        enc_a_d    = enc_a_q ^ (fire & toggle_a);
        enc_b_d    = enc_b_q ^ (fire & ~toggle_a);
        position_d = position_q;
        if (fire) begin
            position_d = fwd ? (position_q + POS_ONE) : (position_q - POS_ONE);
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            step_q     <= 1'b0;
            enc_a_q    <= 1'b0;
            enc_b_q    <= 1'b0;
            position_q <= '0;
            pending_q  <= '0;
            divider_q  <= '0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            step_q     <= step_d;
            enc_a_q    <= enc_a_d;
            enc_b_q    <= enc_b_d;
            position_q <= position_d;
            pending_q  <= pending_d;
            divider_q  <= divider_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.enc_a    = enc_a_q;
    assign bus.enc_b    = enc_b_q;
    assign bus.position = position_q;
    assign bus.pending  = pending_q;
    assign bus.busy     = busy_q;
    assign bus.overflow = overflow_q;

`ifdef QUAD_ENC_INDEX_EN
    localparam int              IDXW     = (CPR > 1) ? $clog2(CPR) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(CPR - 1);
    localparam logic [IDXW-1:0] IDX_ONE  = {{(IDXW-1){1'b0}}, 1'b1};

    logic [IDXW-1:0] index_q, index_d;
    logic            enc_z_q, enc_z_d;

    // CPR is a multiple of 4, so index 0 always lines up with (A,B)=00.
    always_comb begin
        index_d = index_q;
        if (fire) begin
            if (fwd) begin
                index_d = (index_q == IDX_LAST) ? '0 : (index_q + IDX_ONE);
            end else begin
                index_d = (index_q == '0) ? IDX_LAST : (index_q - IDX_ONE);
            end
        end
        enc_z_d = (index_d == '0);
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            index_q <= '0;
            enc_z_q <= 1'b1;
        end else begin
            index_q <= index_d;
            enc_z_q <= enc_z_d;
        end
    end

    assign bus.enc_z = enc_z_q;
`endif

endmodule

// File: tb/tb_quad_enc_gen.sv
// Scoreboard bench for quad_enc_gen: stimulus queues expected A/B transitions,
// a monitor pops and checks each one as the DUT emits it.
module tb_quad_enc_gen;
    localparam int COUNTBITS = 4;
    localparam int DIVBITS   = 16;
    localparam int POSBITS   = 32;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    quad_enc_gen_if #(.COUNTBITS(COUNTBITS), .DIVBITS(DIVBITS), .POSBITS(POSBITS)) bus ();

    quad_enc_gen #(
        .COUNTBITS(COUNTBITS),
        .DIVBITS  (DIVBITS),
        .POSBITS  (POSBITS)
`ifdef QUAD_ENC_INDEX_EN
        ,
        .CPR      (8)
`endif
    ) dut (
        .CLK  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [1:0] ab;
        int         pos;
        int         gap;
    } exp_t;

    exp_t       exp_q[$];
    int         checks_total  = 0;
    int         checks_passed = 0;
    int         cycle         = 0;
    int         model_phase   = 0;
    int         model_pos     = 0;
    logic [1:0] fwd_seq [4];

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check_output(input string name, input longint actual, input longint expected);
        checks_total++;
        if (actual == expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic push_fwd(input int gap);
        exp_t e;
        model_phase = (model_phase + 1) % 4;
        model_pos++;
        e.ab  = fwd_seq[model_phase];
        e.pos = model_pos;
        e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic push_rev(input int gap);
        exp_t e;
        model_phase = (model_phase + 3) % 4;
        model_pos--;
        e.ab  = fwd_seq[model_phase];
        e.pos = model_pos;
        e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_phase = 0;
        model_pos   = 0;
    endtask

    // One step: high for one cycle, low for one cycle; returns at the negedge
    // just after the edge that sampled the step high.
    task automatic apply_stimulus(input logic d);
        @(negedge clk);
        bus.step = 1'b1;
        bus.dir  = d;
        @(negedge clk);
        bus.step = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget, input bit check_busy);
        bit busy_dropped;
        busy_dropped = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
            #1;
            if (check_busy && exp_q.size() != 0 && !bus.busy) busy_dropped = 1'b1;
        end
        check_output({name, "_drained"}, exp_q.size(), 0);
        if (check_busy) check_output({name, "_busy_held"}, busy_dropped, 0);
        exp_q.delete();
    endtask

    // Monitor: every A/B change outside reset must match the next queued entry.
    initial begin
        logic [1:0] prev_ab;
        int         last_cycle;
        exp_t       e;
        prev_ab    = 2'b00;
        last_cycle = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_ab    = {bus.enc_a, bus.enc_b};
                last_cycle = cycle;
            end else if ({bus.enc_a, bus.enc_b} != prev_ab) begin
                check_output("edge_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_output("edge_ab", {bus.enc_a, bus.enc_b}, e.ab);
                    check_output("edge_pos", $signed(bus.position), e.pos);
                    if (e.gap != 0) check_output("edge_gap", cycle - last_cycle, e.gap);
                end
                prev_ab    = {bus.enc_a, bus.enc_b};
                last_cycle = cycle;
            end
        end
    end

    initial begin
        fwd_seq            = '{2'b00, 2'b10, 2'b11, 2'b01};
        reset              = 1'b1;
        bus.step           = 1'b0;
        bus.dir            = 1'b1;
        bus.enable         = 1'b1;
        bus.clear_overflow = 1'b0;
        bus.edge_period    = DIVBITS'(1);

        // Reset values, then one forward step at edge_period=1
        do_reset();
        check_output("rst_a", bus.enc_a, 0);
        check_output("rst_b", bus.enc_b, 0);
        check_output("rst_pos", $signed(bus.position), 0);
        check_output("rst_pending", $signed(bus.pending), 0);
        check_output("rst_busy", bus.busy, 0);
        check_output("rst_ovf", bus.overflow, 0);
`ifdef QUAD_ENC_INDEX_EN
        check_output("rst_z", bus.enc_z, 1);
`endif
        push_fwd(0);
        apply_stimulus(1'b1);
        check_output("t1_pending_n", $signed(bus.pending), 1);
        check_output("t1_busy_n", bus.busy, 1);
        @(negedge clk);
        #1;
        check_output("t1_queue", exp_q.size(), 0);
        check_output("t1_pending", $signed(bus.pending), 0);
        check_output("t1_busy", bus.busy, 0);
        check_output("t1_pos", $signed(bus.position), 1);

        // Eight forward steps paced at edge_period=10
        do_reset();
        bus.edge_period = DIVBITS'(10);
        for (int i = 0; i < 8; i++) begin
            push_fwd((i == 0) ? 0 : 10);
            apply_stimulus(1'b1);
        end
        wait_drain("t2", 200, 1'b1);
        check_output("t2_pos", $signed(bus.position), 8);
        check_output("t2_ab", {bus.enc_a, bus.enc_b}, 2'b00);
        check_output("t2_busy", bus.busy, 0);

        // Five forward then five reverse: one edge out, one edge back
        do_reset();
        bus.edge_period = DIVBITS'(100);
        push_fwd(0);
        for (int i = 0; i < 5; i++) apply_stimulus(1'b1);
        for (int i = 0; i < 5; i++) apply_stimulus(1'b0);
        push_rev(100);
        wait_drain("t3", 300, 1'b0);
        check_output("t3_pos", $signed(bus.position), 0);
        check_output("t3_ab", {bus.enc_a, bus.enc_b}, 2'b00);
        check_output("t3_pending", $signed(bus.pending), 0);

        // Saturation: divider still running from the last edge, 9 steps -> pending 7
        bus.edge_period = DIVBITS'(1000);
        for (int i = 0; i < 9; i++) apply_stimulus(1'b1);
        for (int i = 0; i < 7; i++) push_fwd((i == 0) ? 100 : 1000);
        check_output("t4_pending_sat", $signed(bus.pending), 7);
        check_output("t4_ovf_set", bus.overflow, 1);
        @(negedge clk);
        bus.clear_overflow = 1'b1;
        @(negedge clk);
        bus.clear_overflow = 1'b0;
        check_output("t4_ovf_clr", bus.overflow, 0);
        wait_drain("t4", 8000, 1'b1);
        check_output("t4_pos", $signed(bus.position), 7);
        check_output("t4_pending", $signed(bus.pending), 0);

        // Disable with pending=3, steps while disabled, then re-enable
        do_reset();
        bus.edge_period = DIVBITS'(1000);
        push_fwd(0);
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1);
        check_output("t5_pending3", $signed(bus.pending), 3);
        @(negedge clk);
        bus.enable = 1'b0;
        @(negedge clk);
        check_output("t5_pending_off", $signed(bus.pending), 0);
        check_output("t5_busy_off", bus.busy, 0);
        check_output("t5_pos_hold", $signed(bus.position), 1);
        check_output("t5_ab_hold", {bus.enc_a, bus.enc_b}, 2'b10);
        apply_stimulus(1'b1);
        apply_stimulus(1'b0);
        check_output("t5_pending_ign", $signed(bus.pending), 0);
        @(negedge clk);
        bus.enable = 1'b1;
        push_fwd(0);
        apply_stimulus(1'b1);
        wait_drain("t5", 10, 1'b0);
        check_output("t5_pos", $signed(bus.position), 2);
        check_output("t5_pending", $signed(bus.pending), 0);

`ifdef QUAD_ENC_INDEX_EN
        // Index pulse over one revolution with CPR=8
        do_reset();
        bus.edge_period = DIVBITS'(1);
        check_output("t6_z_rst", bus.enc_z, 1);
        push_fwd(0);
        apply_stimulus(1'b1);
        @(negedge clk);
        check_output("t6_z_low", bus.enc_z, 0);
        for (int i = 0; i < 7; i++) begin
            push_fwd(0);
            apply_stimulus(1'b1);
        end
        wait_drain("t6", 20, 1'b0);
        check_output("t6_z_high", bus.enc_z, 1);
        check_output("t6_pos", $signed(bus.position), 8);
        check_output("t6_ab", {bus.enc_a, bus.enc_b}, 2'b00);
        push_rev(0);
        apply_stimulus(1'b0);
        wait_drain("t6r", 10, 1'b0);
        check_output("t6_z_rev", bus.enc_z, 0);
        check_output("t6_pos_rev", $signed(bus.position), 7);
`endif

        repeat (3) @(negedge clk);
        check_output("final_queue", exp_q.size(), 0);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/quad_enc_gen.md
Name: quad_enc_gen

Overview:
- Quadrature encoder generator: the transmit side of the quadrature interface that quad_enc decodes.
- Converts step/dir pulses into rate-limited A/B quadrature edges, one quadrature state change per step.
- Used to emulate an encoder for loopback testing of quad_enc, and to drive external motion controllers from the stepper step/dir lines.
- Sits next to spi_state_machine in rapcore and is fed by the same step/dir/enable wires.

Parameters:
- COUNTBITS, 16, width of the signed pending-step accumulator.
- DIVBITS, 16, width of the edge-spacing divider and of edge_period.
- POSBITS, 32, width of the signed emitted-position counter.

Ports:
- CLK  input  1  system clock.
- reset  input  1  synchronous reset, active-high.
- step  input  1  step request; each rising edge counts as one step.
- dir  input  1  1 = forward (+1), 0 = reverse (-1); sampled with the step edge.
- enable  input  1  0 = generator disabled.
- edge_period  input  DIVBITS  minimum clocks between consecutive A/B transitions; 0 is treated as 1.
- clear_overflow  input  1  single-cycle clear of the overflow flag.
- enc_a  output  1  quadrature channel A.
- enc_b  output  1  quadrature channel B.
- position  output  POSBITS  signed count of emitted transitions.
- pending  output  COUNTBITS  signed count of steps not yet emitted.
- busy  output  1  high while pending != 0.
- overflow  output  1  sticky; set when a step is dropped at saturation.

Behaviour:
- Reset: enc_a=0, enc_b=0, position=0, pending=0, busy=0, overflow=0, divider=0, step_q=0.
- Step detection:
  - step_q registers step every cycle.
  - step_ev = step & ~step_q & enable.
  - delta_in = +1 if dir=1, -1 if dir=0.
- Edge engine:
  - Fires when divider==0 && pending!=0 && enable.
  - Forward (pending>0): (A,B) advances 00 -> 10 -> 11 -> 01 -> 00.
  - Reverse (pending<0): the same sequence in the opposite direction.
  - Exactly one channel toggles per fire.
  - position changes by ±1 and wraps modulo 2^POSBITS.
  - pending moves one step toward 0 (delta_out).
- Divider:
  - On fire, loads max(edge_period,1)-1.
  - Otherwise decrements while nonzero.
  - Stays at 0 when idle, so the first edge after idle is not delayed.
- Simultaneous events:
  - next pending = pending + delta_in - delta_out, evaluated in COUNTBITS+1 bits.
  - Saturates at +(2^(COUNTBITS-1)-1) and -(2^(COUNTBITS-1)-1).
  - A step that would exceed the limit is dropped and overflow is set.
  - A fire in the same cycle still applies.
- Latency:
  - Step high first sampled at edge n: pending is updated at edge n.
  - A/B changes at edge n+1 (2 registered stages); busy follows pending.
- Rate: with edge_period=P (P>=1), consecutive transitions are exactly P cycles apart while pending!=0.
- Direction reversal: if steps reverse while pending!=0, the pending net count cancels. No transitions are emitted for cancelled steps.
- enable=0:
  - pending and divider are forced to 0.
  - Steps are ignored.
  - enc_a/enc_b and position hold their values.
  - overflow holds.
- clear_overflow: clears overflow unless a new overflow occurs in the same cycle; set has priority.
- Reset mid-operation: everything returns to reset values next edge; queued steps are discarded.
- enc_a/enc_b are driven directly from flops (glitch-free).

Optional Feature:
- Macro QUAD_ENC_INDEX_EN.
- When defined:
  - Adds parameter CPR (default 4000, counts per revolution; transitions, multiple of 4).
  - Adds output enc_z (1 bit).
  - Adds an index counter 0..CPR-1 that moves with every fire: forward wraps CPR-1 -> 0, reverse wraps 0 -> CPR-1.
  - enc_z=1 while the index counter==0, which is always coincident with (A,B)=00.
  - Reset: index counter=0, enc_z=1.
- When undefined: no enc_z port and no index counter; behaviour otherwise identical.

Test Plan:
- Reset, then a single forward step, edge_period=1 -> at edge n+1 (A,B)=10, position=1, pending=0, busy low after edge n+1.
- 8 forward steps in consecutive 2-cycle pulses, edge_period=10 -> sequence 10,11,01,00,10,11,01,00; edges exactly 10 cycles apart; position=8; busy high throughout until the last edge.
- 5 forward then 5 reverse steps queued before the first fire (edge_period=100) -> at most 1 transition emitted, then one reverse transition back; final position=0, (A,B)=00.
- COUNTBITS=4, edge_period=1000, 9 forward steps -> pending saturates at 7, overflow=1; clear_overflow pulse -> overflow=0; the following 7 transitions bring position to 7.
- enable dropped with pending=3 -> pending=0 next edge, A/B and position frozen; steps while disabled leave pending at 0; re-enable + 1 step -> one transition.
- QUAD_ENC_INDEX_EN with CPR=8: 8 forward steps -> enc_z low after edge 1, high again at position 8 with (A,B)=00; 1 reverse step -> enc_z low.
